fifo_ctrl: RTL and testbench

//  Controller for an 8-entry circular FIFO built on the 2-read/1-write register file.

---
 rtl/fifo_ctrl_pkg.sv | 12 +
 rtl/fifo_ctrl_if.sv | 18 +
 rtl/fifo_ctrl_edge_pulse.sv | 28 ++
 rtl/fifo_ctrl.sv | 93 +++++++++
 tb/tb_fifo_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared sizing for the FIFO controller, its register file and the FIFO top level.
package fifo_ctrl_pkg;

  localparam int WIDTH_DEF     = 4;
  localparam int WORD_LINE_DEF = 3;
  localparam int DEPTH_DEF     = 1 << WORD_LINE_DEF;

  function automatic int depth_of(input int word_line);
    return 1 << word_line;
  endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// Register-file port bundle: one write port and asynchronous read port 0.
interface fifo_ctrl_if
  import fifo_ctrl_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int WORD_LINE = WORD_LINE_DEF
);

  logic                 rf_we;
  logic [WORD_LINE-1:0] rf_wa;
  logic [WIDTH-1:0]     rf_wd;
  logic [WORD_LINE-1:0] rf_ra0;
  logic [WIDTH-1:0]     rf_rd0;

  modport master (output rf_we, output rf_wa, output rf_wd, output rf_ra0, input rf_rd0);
  modport slave  (input rf_we, input rf_wa, input rf_wd, input rf_ra0, output rf_rd0);

endinterface

// File: rtl/fifo_ctrl_edge_pulse.sv
// Synchronises a slow level input and emits one pulse per rising edge.
module fifo_ctrl_edge_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic x,
  output logic pulse
);

  logic s1_r;
  logic s2_r;
  logic s3_r;

  // synchroniser plus one delay stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= x;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  assign pulse = s2_r & ~s3_r;

endmodule

// File: rtl/fifo_ctrl.sv
// Circular FIFO controller driving an external 2-read/1-write register file.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int WORD_LINE = WORD_LINE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_in,
  input  logic                 en_out,
  input  logic [WIDTH-1:0]     din,
  output logic [WIDTH-1:0]     dout,
  output logic                 dout_vld,
  output logic                 full,
  output logic                 empty,
  output logic [WORD_LINE:0]   count,
  output logic                 err,
  fifo_ctrl_if.master          rf
);

  localparam int CW = WORD_LINE + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(depth_of(WORD_LINE));

  logic                 push_p_s;
  logic                 pop_p_s;
  logic                 do_push_s;
  logic                 do_pop_s;
  logic                 full_s;
  logic                 empty_s;
  logic [CW-1:0]        count_nxt_s;
  logic [WORD_LINE-1:0] head_r;
  logic [WORD_LINE-1:0] tail_r;
  logic [CW-1:0]        count_r;
  logic [WIDTH-1:0]     dout_r;
  logic                 dout_vld_r;
  logic                 err_r;

  fifo_ctrl_edge_pulse u_push_pulse (.clk(clk), .rst_n(rst_n), .x(en_in),  .pulse(push_p_s));
  fifo_ctrl_edge_pulse u_pop_pulse  (.clk(clk), .rst_n(rst_n), .x(en_out), .pulse(pop_p_s));

  // flags as they stand at the start of the cycle gate both operations
  assign full_s    = (count_r == DEPTH_CNT);
  assign empty_s   = (count_r == CW'(0));
  assign do_push_s = push_p_s & ~full_s;
  assign do_pop_s  = pop_p_s & ~empty_s;

  // occupancy update for every push/pop combination
  always_comb begin
    count_nxt_s = count_r;
    case ({do_push_s, do_pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // pointers, occupancy, popped data and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r     <= '0;
      tail_r     <= '0;
      count_r    <= '0;
      dout_r     <= '0;
      dout_vld_r <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      count_r    <= count_nxt_s;
      dout_vld_r <= do_pop_s;
      err_r      <= (push_p_s & full_s) | (pop_p_s & empty_s);
      if (do_push_s) begin
        tail_r <= tail_r + WORD_LINE'(1);
      end
      if (do_pop_s) begin
        head_r <= head_r + WORD_LINE'(1);
        dout_r <= rf.rf_rd0;
      end
    end
  end

  assign rf.rf_we  = do_push_s;
  assign rf.rf_wa  = tail_r;
  assign rf.rf_wd  = din;
  assign rf.rf_ra0 = head_r;

  assign dout     = dout_r;
  assign dout_vld = dout_vld_r;
  assign err      = err_r;
  assign count    = count_r;
  assign full     = full_s;
  assign empty    = empty_s;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with an RF model and queue scoreboard.
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_in;
  logic       en_out;
  logic [3:0] din;
  logic [3:0] dout;
  logic       dout_vld;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       err;

  always #5 clk = ~clk;

  fifo_ctrl_if #(.WIDTH(4), .WORD_LINE(3)) rf_bus ();

  // register file model: synchronous write, asynchronous read
  logic [3:0] mem [0:7];
  always @(posedge clk) if (rf_bus.rf_we) mem[rf_bus.rf_wa] <= rf_bus.rf_wd;
  assign rf_bus.rf_rd0 = mem[rf_bus.rf_ra0];

  fifo_ctrl #(.WIDTH(4), .WORD_LINE(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_in    (en_in),
    .en_out   (en_out),
    .din      (din),
    .dout     (dout),
    .dout_vld (dout_vld),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .err      (err),
    .rf       (rf_bus)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  int         err_pend = 0;
  logic [6:0] wr_q [$];
  logic [3:0] rd_q [$];
  logic [3:0] model_q [$];
  logic [2:0] m_tail;
  logic [3:0] last_dout;
  logic [6:0] wr_e;
  logic [3:0] rd_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: every DUT output event must match the head of its expectation queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (rf_bus.rf_we) begin
        check("rf_we_expected", 32'(wr_q.size() != 0), 32'd1);
        if (wr_q.size() != 0) begin
          wr_e = wr_q.pop_front();
          check("rf_wa", 32'(rf_bus.rf_wa), 32'(wr_e[6:4]));
          check("rf_wd", 32'(rf_bus.rf_wd), 32'(wr_e[3:0]));
        end
      end
      if (dout_vld) begin
        check("dout_vld_expected", 32'(rd_q.size() != 0), 32'd1);
        if (rd_q.size() != 0) begin
          rd_e = rd_q.pop_front();
          check("dout", 32'(dout), 32'(rd_e));
        end
      end
      if (err) begin
        check("err_expected", 32'(err_pend > 0), 32'd1);
        if (err_pend > 0) err_pend--;
      end
    end
  end

  task automatic model_reset();
    model_q.delete();
    m_tail    = 3'd0;
    last_dout = 4'd0;
  endtask

  // update the model from the flags at issue time, then drive both levels
  task automatic op(input logic [3:0] d, input logic ins, input logic outs);
    bit was_full;
    bit was_empty;
    was_full  = (model_q.size() == 8);
    was_empty = (model_q.size() == 0);
    if (outs) begin
      if (was_empty) err_pend++;
      else begin
        last_dout = model_q.pop_front();
        rd_q.push_back(last_dout);
      end
    end
    if (ins) begin
      if (was_full) err_pend++;
      else begin
        wr_q.push_back({m_tail, d});
        model_q.push_back(d);
        m_tail = m_tail + 3'd1;
      end
    end
    @(posedge clk); #1;
    din = d; en_in = ins; en_out = outs;
    repeat (4) @(posedge clk);
    #1;
    en_in = 1'b0; en_out = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("count_after_op", 32'(count), 32'(model_q.size()));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full",  32'(full),  32'd0);
    check("rst_dout",  32'(dout),  32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  logic [3:0] c_vals [3] = '{4'hC, 4'hD, 4'hE};

  initial begin
    rst_n = 1'b0; en_in = 1'b0; en_out = 1'b0; din = 4'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("idle_empty",    32'(empty),    32'd1);
    check("idle_full",     32'(full),     32'd0);
    check("idle_count",    32'(count),    32'd0);
    check("idle_dout",     32'(dout),     32'd0);
    check("idle_dout_vld", 32'(dout_vld), 32'd0);
    check("idle_err",      32'(err),      32'd0);

    // push 3,5,9 then drain
    op(4'd3, 1'b1, 1'b0);
    op(4'd5, 1'b1, 1'b0);
    op(4'd9, 1'b1, 1'b0);
    repeat (3) op(4'd0, 1'b0, 1'b1);
    check("t2_empty", 32'(empty), 32'd1);

    // fill from a fresh reset, then overflow
    do_reset();
    for (int i = 0; i < 8; i++) op(4'(i), 1'b1, 1'b0);
    check("t3_full",  32'(full),  32'd1);
    check("t3_count", 32'(count), 32'd8);
    op(4'hF, 1'b1, 1'b0);
    check("t3_mem0_kept", 32'(mem[0]), 32'd0);
    check("t3_full_still", 32'(full), 32'd1);

    // wrap: pop 3, push 3 into reused slots, drain in FIFO order
    repeat (3) op(4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) op(c_vals[i], 1'b1, 1'b0);
    check("t4_full", 32'(full), 32'd1);
    repeat (8) op(4'd0, 1'b0, 1'b1);

    // pop on empty, then simultaneous push and pop at empty
    op(4'd0, 1'b0, 1'b1);
    check("t5_dout_hold", 32'(dout), 32'(last_dout));
    check("t5_count", 32'(count), 32'd0);
    op(4'd6, 1'b1, 1'b1);
    check("t5_both_count", 32'(count), 32'd1);
    op(4'd0, 1'b0, 1'b1);

    // held level gives one push, then reset with four entries present
    wr_q.push_back({m_tail, 4'd1});
    model_q.push_back(4'd1);
    m_tail = m_tail + 3'd1;
    @(posedge clk); #1;
    din = 4'd1; en_in = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    en_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t6_held_count", 32'(count), 32'd1);
    op(4'd2, 1'b1, 1'b0);
    op(4'd3, 1'b1, 1'b0);
    op(4'd4, 1'b1, 1'b0);
    check("t6_count4", 32'(count), 32'd4);
    do_reset();

    check("wr_q_drained",  32'(wr_q.size()), 32'd0);
    check("rd_q_drained",  32'(rd_q.size()), 32'd0);
    check("err_drained",   32'(err_pend),    32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
